freelist: RTL and testbench
===========================

FREELIST -- requirements
Module: freelist

Interface
REQ-001 SHALL expose parameters: DEPTH, 32, number of free-list entries; PREG_W, 6, physical register tag width.
REQ-002 SHALL expose ports: clock  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL expose ports: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL expose ports: disp2fl_instr0_alloc_en  in  1  dispatch instr0 consumes one preg this cycle.
REQ-005 SHALL expose ports: disp2fl_instr1_alloc_en  in  1  dispatch instr1 consumes one preg this cycle.
REQ-006 SHALL expose ports: fl2disp_instr0_prd  out  6  preg offered to instr0.
REQ-007 SHALL expose ports: fl2disp_instr1_prd  out  6  preg offered to instr1.
REQ-008 SHALL expose ports: fl2disp_can_alloc  out  1  two pregs available and state IDLE.
REQ-009 SHALL expose ports: rob2fl_free0_en / rob2fl_free0_prd  in  1/6  commit slot 0 returns old prd.
REQ-010 SHALL expose ports: rob2fl_free1_en / rob2fl_free1_prd  in  1/6  commit slot 1 returns old prd.
REQ-011 SHALL expose ports: rob2fl_commit0_alloc / rob2fl_commit1_alloc  in  1/1  committing instr had allocated a prd.
REQ-012 SHALL expose ports: rob_state  in  2  shared ROB state encoding (IDLE/ROLLBACK/WALK).
REQ-013 SHALL expose ports: walking_valid0 / walking_valid1  in  1/1  walked instr re-claims its prd.
REQ-014 SHALL expose ports: fl2top_free_count  out  6  free entries, 0..32.
REQ-015 SHALL expose ports: fl2top_overflow  out  1  one-cycle pulse on dropped free.

Function
REQ-016 SHALL hold a DEPTH-entry circular array of 6-bit tags with 6-bit pointers spec_head, arch_head, tail (5-bit index + wrap bit).
REQ-017 SHALL compute count = tail - spec_head (mod 64); fl2top_free_count = count.
REQ-018 SHALL drive fl2disp_instr0_prd = entry[spec_head]; fl2disp_instr1_prd = entry[spec_head + instr0_alloc_en] (combinational).
REQ-019 SHALL assert fl2disp_can_alloc only when count >= 2 and rob_state == IDLE.
REQ-020 SHALL, when can_alloc, advance spec_head by instr0_alloc_en + instr1_alloc_en; alloc enables while can_alloc=0 SHALL be ignored (no pointer change).
REQ-021 SHALL write free0 at entry[tail], free1 at entry[tail + free0_en]; tail advances by free0_en + free1_en.
REQ-022 SHALL, if a free would make count exceed DEPTH (using post-alloc count), drop that free, not move tail for it, and pulse fl2top_overflow next cycle.
REQ-023 SHALL advance arch_head by commit0_alloc + commit1_alloc each cycle, independent of rob_state.
REQ-024 SHALL, in ROLLBACK, set spec_head <= arch_head (plus this cycle's commit increment); allocs ignored.
REQ-025 SHALL, in WALK, advance spec_head by walking_valid0 + walking_valid1; allocs ignored.
REQ-026 SHALL accept frees in every rob_state; simultaneous alloc and free SHALL both apply, with alloc reading pre-write entries.
REQ-027 SHALL handle pointer wrap at index 31->0 by toggling the wrap bit; count==32 full, count==0 empty.

Reset
REQ-028 SHALL on reset load entry[i] = 32 + i for i = 0..31, spec_head = arch_head = 0, tail = 6'b100000, overflow = 0.
REQ-029 SHALL after reset output count = 32, instr0_prd = 32, instr1_prd = 32 (no alloc0) / 33 (alloc0=1), can_alloc = 1 when IDLE.
REQ-030 SHALL let reset win over all same-cycle alloc, free, rollback, walk inputs.

Verification
REQ-031 SHALL cover: reset, alloc0+alloc1 one cycle -> prds 32/33, next cycle count = 30, instr0_prd = 34.
REQ-032 SHALL cover: 15 dual allocs -> count = 2; one more dual alloc -> count = 0, can_alloc = 0; further alloc_en -> no change.
REQ-033 SHALL cover: count = 0, free0 = 5, free1 = 7 -> count = 2; later dual alloc yields 5 then 7 (FIFO order, wrap exercised).
REQ-034 SHALL cover: full (count = 32), free0 = 9 -> dropped, overflow pulses 1 cycle, count stays 32.
REQ-035 SHALL cover: 4 allocs, 1 commit0_alloc, ROLLBACK -> spec_head = arch_head (count = 31); WALK with walking_valid0+1 -> count = 29; can_alloc = 0 throughout.
REQ-036 SHALL cover: reset asserted mid-WALK with frees active -> all state equals REQ-028 values next cycle.

Source files
------------

// File: rtl/freelist_if.sv
// freelist_if: groups the dispatch, commit, walk and status signals of the
// physical-register free list.
//   slave  : the free list itself (consumes alloc/free/walk requests,
//            drives offered tags, can_alloc, free count and overflow).
//   master : the surrounding pipeline (dispatch + ROB side).
interface freelist_if #(
  parameter int DEPTH  = 32,
  parameter int PREG_W = 6
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              disp2fl_instr0_alloc_en;
  logic              disp2fl_instr1_alloc_en;
  logic [PREG_W-1:0] fl2disp_instr0_prd;
  logic [PREG_W-1:0] fl2disp_instr1_prd;
  logic              fl2disp_can_alloc;
  logic              rob2fl_free0_en;
  logic [PREG_W-1:0] rob2fl_free0_prd;
  logic              rob2fl_free1_en;
  logic [PREG_W-1:0] rob2fl_free1_prd;
  logic              rob2fl_commit0_alloc;
  logic              rob2fl_commit1_alloc;
  logic [1:0]        rob_state;
  logic              walking_valid0;
  logic              walking_valid1;
  logic [CNT_W-1:0]  fl2top_free_count;
  logic              fl2top_overflow;

  modport slave (
    input  disp2fl_instr0_alloc_en, disp2fl_instr1_alloc_en,
    input  rob2fl_free0_en, rob2fl_free0_prd, rob2fl_free1_en, rob2fl_free1_prd,
    input  rob2fl_commit0_alloc, rob2fl_commit1_alloc,
    input  rob_state, walking_valid0, walking_valid1,
    output fl2disp_instr0_prd, fl2disp_instr1_prd, fl2disp_can_alloc,
    output fl2top_free_count, fl2top_overflow
  );

  modport master (
    output disp2fl_instr0_alloc_en, disp2fl_instr1_alloc_en,
    output rob2fl_free0_en, rob2fl_free0_prd, rob2fl_free1_en, rob2fl_free1_prd,
    output rob2fl_commit0_alloc, rob2fl_commit1_alloc,
    output rob_state, walking_valid0, walking_valid1,
    input  fl2disp_instr0_prd, fl2disp_instr1_prd, fl2disp_can_alloc,
    input  fl2top_free_count, fl2top_overflow
  );
endinterface

// File: rtl/freelist.sv
// freelist: circular free list of physical register tags for a 2-wide
// rename/dispatch stage.
//   clock, reset : sole clock, synchronous active-high reset.
//   fl (slave)   : dispatch allocates up to two tags per cycle from spec_head,
//                  ROB commit returns up to two tags at tail, ROB commit also
//                  advances arch_head; ROLLBACK snaps spec_head back to
//                  arch_head and WALK re-claims walked tags.
// Pointers carry one wrap bit above the index so full (count == DEPTH) and
// empty (count == 0) are distinguishable.
module freelist #(
  parameter int DEPTH  = 32,
  parameter int PREG_W = 6
) (
  input  logic     clock,
  input  logic     reset,
  freelist_if.slave fl
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  localparam logic [1:0] ROB_IDLE     = 2'd0;
  localparam logic [1:0] ROB_ROLLBACK = 2'd1;
  localparam logic [1:0] ROB_WALK     = 2'd2;

  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  function automatic logic [PTR_W-1:0] pair_sum(input logic a, input logic b);
    return PTR_W'(a) + PTR_W'(b);
  endfunction

  logic [PREG_W-1:0] entry_q [DEPTH];
  logic [PREG_W-1:0] entry_d [DEPTH];
  logic [PTR_W-1:0]  spec_head_q, spec_head_d;
  logic [PTR_W-1:0]  arch_head_q, arch_head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic              overflow_q, overflow_d;

  logic [PTR_W-1:0]  count;
  logic [PTR_W-1:0]  count_post;
  logic [PTR_W-1:0]  count_post1;
  logic              can_alloc;
  logic              keep0, keep1;
  logic [IDX_W-1:0]  rd1_idx, wr0_idx, wr1_idx;

  assign count     = tail_q - spec_head_q;
  assign can_alloc = (count >= PTR_W'(2)) && (fl.rob_state == ROB_IDLE);

  // instr1 sees the tag after instr0's only when instr0 actually takes one.
  assign rd1_idx = spec_head_q[IDX_W-1:0] + IDX_W'(fl.disp2fl_instr0_alloc_en);

  assign fl.fl2disp_instr0_prd = entry_q[spec_head_q[IDX_W-1:0]];
  assign fl.fl2disp_instr1_prd = entry_q[rd1_idx];
  assign fl.fl2disp_can_alloc  = can_alloc;
  assign fl.fl2top_free_count  = count;
  assign fl.fl2top_overflow    = overflow_q;

  always_comb begin
    arch_head_d = arch_head_q + pair_sum(fl.rob2fl_commit0_alloc, fl.rob2fl_commit1_alloc);

    spec_head_d = spec_head_q;
    case (fl.rob_state)
      // Rollback lands on the architectural head including this cycle's commits.
      ROB_ROLLBACK: spec_head_d = arch_head_d;
      ROB_WALK:     spec_head_d = spec_head_q + pair_sum(fl.walking_valid0, fl.walking_valid1);
      // Unused encoding falls here too, but can_alloc is 0 there so nothing moves.
      default: begin
        if (can_alloc) begin
          spec_head_d = spec_head_q + pair_sum(fl.disp2fl_instr0_alloc_en,
                                               fl.disp2fl_instr1_alloc_en);
        end
      end
    endcase

    // Overflow is judged against the count after this cycle's head movement,
    // so an alloc and a free in the same cycle at full both succeed.
    count_post  = tail_q - spec_head_d;
    keep0       = fl.rob2fl_free0_en && (count_post < DEPTH_P);
    count_post1 = count_post + PTR_W'(keep0);
    keep1       = fl.rob2fl_free1_en && (count_post1 < DEPTH_P);

    wr0_idx = tail_q[IDX_W-1:0];
    wr1_idx = wr0_idx + IDX_W'(keep0);

    // Reads above use entry_q, so same-cycle allocs see pre-write contents.
    entry_d = entry_q;
    if (keep0) entry_d[wr0_idx] = fl.rob2fl_free0_prd;
    if (keep1) entry_d[wr1_idx] = fl.rob2fl_free1_prd;

    tail_d     = tail_q + pair_sum(keep0, keep1);
    overflow_d = (fl.rob2fl_free0_en && !keep0) || (fl.rob2fl_free1_en && !keep1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= PREG_W'(DEPTH + i);
      end
      spec_head_q <= '0;
      arch_head_q <= '0;
      tail_q      <= DEPTH_P;
      overflow_q  <= 1'b0;
    end else begin
      entry_q     <= entry_d;
      spec_head_q <= spec_head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
      overflow_q  <= overflow_d;
    end
  end
endmodule

// File: tb/tb_freelist.sv
module tb_freelist;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RB   = 2'd1;
  localparam logic [1:0] WK   = 2'd2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  freelist_if #(.DEPTH(32), .PREG_W(6)) fif ();
  freelist #(.DEPTH(32), .PREG_W(6)) dut (.clock(clock), .reset(reset), .fl(fif.slave));

  // One row = inputs held for one cycle and the outputs expected in that same
  // cycle (before the edge that consumes the inputs). -1 means not checked.
  typedef struct {
    string      name;
    logic       rst;
    logic       a0, a1;
    logic       f0e;
    logic [5:0] f0;
    logic       f1e;
    logic [5:0] f1;
    logic       c0, c1;
    logic [1:0] st;
    logic       w0, w1;
    int         e_cnt, e_can, e_p0, e_p1, e_ovf;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(string n, int cnt, int can, int p0, int p1, int ovf);
    vec_t r;
    r.name = n; r.rst = 1'b0; r.a0 = 1'b0; r.a1 = 1'b0;
    r.f0e = 1'b0; r.f0 = '0; r.f1e = 1'b0; r.f1 = '0;
    r.c0 = 1'b0; r.c1 = 1'b0; r.st = IDLE; r.w0 = 1'b0; r.w1 = 1'b0;
    r.e_cnt = cnt; r.e_can = can; r.e_p0 = p0; r.e_p1 = p1; r.e_ovf = ovf;
    return r;
  endfunction

  function automatic vec_t alloc2(vec_t r);
    r.a0 = 1'b1; r.a1 = 1'b1;
    return r;
  endfunction

  function automatic vec_t frees(vec_t r, logic e0, int t0, logic e1, int t1);
    r.f0e = e0; r.f0 = 6'(t0); r.f1e = e1; r.f1 = 6'(t1);
    return r;
  endfunction

  task automatic chk(string n, string f, logic [31:0] act, int exp);
    if (exp >= 0) begin
      checks++;
      if (act !== 32'(exp)) begin
        failures++;
        $display("FAIL %s.%s actual=%0d expected=%0d", n, f, act, exp);
      end
    end
  endtask

  task automatic drive(vec_t v);
    reset                        = v.rst;
    fif.disp2fl_instr0_alloc_en  = v.a0;
    fif.disp2fl_instr1_alloc_en  = v.a1;
    fif.rob2fl_free0_en          = v.f0e;
    fif.rob2fl_free0_prd         = v.f0;
    fif.rob2fl_free1_en          = v.f1e;
    fif.rob2fl_free1_prd         = v.f1;
    fif.rob2fl_commit0_alloc     = v.c0;
    fif.rob2fl_commit1_alloc     = v.c1;
    fif.rob_state                = v.st;
    fif.walking_valid0           = v.w0;
    fif.walking_valid1           = v.w1;
  endtask

  initial begin
    vec_t t;
    vec_t e;

    // Dual allocation from reset, then drain to empty.
    vecs.push_back(mk("rst_state", 32, 1, 32, 32, 0));
    vecs.push_back(alloc2(mk("dual0", 32, 1, 32, 33, 0)));
    vecs.push_back(mk("after_dual", 30, 1, 34, 34, 0));
    for (int i = 0; i < 14; i++)
      vecs.push_back(alloc2(mk("dual_run", 30 - 2*i, 1, 34 + 2*i, 35 + 2*i, 0)));
    vecs.push_back(alloc2(mk("last_pair", 2, 1, 62, 63, 0)));
    vecs.push_back(alloc2(mk("empty_alloc", 0, 0, -1, -1, 0)));
    vecs.push_back(mk("empty_hold", 0, 0, -1, -1, 0));

    // Frees into an empty list wrap past index 31 and come back in FIFO order.
    vecs.push_back(frees(mk("free_5_7", 0, 0, -1, -1, 0), 1'b1, 5, 1'b1, 7));
    vecs.push_back(mk("after_free", 2, 1, 5, 5, 0));
    vecs.push_back(alloc2(mk("alloc_5_7", 2, 1, 5, 7, 0)));

    // Fill to full with tags 8..39, then overflow corners.
    for (int k = 0; k < 16; k++)
      vecs.push_back(frees(mk("fill", 2*k, (k >= 1) ? 1 : 0, (k >= 1) ? 8 : -1,
                              (k >= 1) ? 8 : -1, 0), 1'b1, 8 + 2*k, 1'b1, 9 + 2*k));
    vecs.push_back(frees(mk("full_drop", 32, 1, 8, 8, 0), 1'b1, 9, 1'b0, 0));
    vecs.push_back(mk("ovf_pulse", 32, 1, 8, 8, 1));
    t = frees(mk("alloc1_free2", 32, 1, 8, 9, 0), 1'b1, 50, 1'b1, 51); t.a0 = 1'b1;
    vecs.push_back(t);
    vecs.push_back(mk("partial_ovf", 32, 1, 9, 9, 1));
    vecs.push_back(mk("partial_clr", 32, 1, 9, 9, 0));

    // Rollback and walk after a fresh reset.
    t = mk("reset_b", -1, -1, -1, -1, -1); t.rst = 1'b1;
    vecs.push_back(t);
    vecs.push_back(alloc2(mk("rb_alloc_a", 32, 1, 32, 33, 0)));
    vecs.push_back(alloc2(mk("rb_alloc_b", 30, 1, 34, 35, 0)));
    t = mk("rb_commit", 28, 1, 36, 36, 0); t.c0 = 1'b1;
    vecs.push_back(t);
    t = alloc2(mk("rb_roll", 28, 0, -1, -1, 0)); t.st = RB;
    vecs.push_back(t);
    t = mk("rb_walk", 31, 0, 33, 34, 0); t.st = WK; t.w0 = 1'b1; t.w1 = 1'b1; t.a0 = 1'b1;
    vecs.push_back(t);
    t = frees(mk("walk_reset", 29, 0, 35, -1, 0), 1'b1, 3, 1'b1, 4);
    t.st = WK; t.w0 = 1'b1; t.c0 = 1'b1; t.rst = 1'b1;
    vecs.push_back(t);
    vecs.push_back(mk("post_reset", 32, 1, 32, 32, 0));
    t = mk("rb_commit2", 32, 0, -1, -1, 0); t.st = RB; t.c0 = 1'b1; t.c1 = 1'b1;
    vecs.push_back(t);
    t = mk("after_rb2", 30, 1, 34, 35, 0); t.a0 = 1'b1;
    vecs.push_back(t);

    drive(mk("idle", -1, -1, -1, -1, -1));
    reset = 1'b1;
    repeat (2) @(posedge clock);

    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge clock);
      #1;
      drive(vecs[k]);
      exp_q.push_back(vecs[k]);
      @(negedge clock);
      e = exp_q.pop_front();
      chk(e.name, "count",     32'(fif.fl2top_free_count), e.e_cnt);
      chk(e.name, "can_alloc", 32'(fif.fl2disp_can_alloc), e.e_can);
      chk(e.name, "prd0",      32'(fif.fl2disp_instr0_prd), e.e_p0);
      chk(e.name, "prd1",      32'(fif.fl2disp_instr1_prd), e.e_p1);
      chk(e.name, "overflow",  32'(fif.fl2top_overflow), e.e_ovf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
